// File: rtl/msgmii_pkg.sv
// Shared encodings for the MII/GMII rate-adaptation path toward the SGMII PCS.
// Holds the line-rate codes and the nibble-assembly state enumeration.
// Pure declarations; no logic, no latency, no backpressure.
package msgmii_pkg;

  // Line-rate codes as driven on the speed input; 2'b11 is treated as 10.
  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_10   = 2'b00;

  // Nibble-assembly states used at 10/100.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NIB_LO = 2'd1,
    NIB_HI = 2'd2
  } nib_state_e;

endpackage

// File: rtl/msgmii_cnvtx.sv
// MAC-to-GMII transmit converter: byte pass-through at 1000, nibble-pair assembly at 10/100.
// Latency: 1 cycle at 1000; at 10/100 a byte is registered on the slot carrying its high nibble.
// No backpressure: pacing comes from the MAC via nib_en. Odd-frame counter only with MSGMII_CNVTX_STATS_EN.
module msgmii_cnvtx
  import msgmii_pkg::*;
#(
  parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic       nib_en,
  input  logic [7:0] mac_txd,
  input  logic       mac_tx_en,
  input  logic       mac_tx_er,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic [7:0] odd_cnt
);

  nib_state_e state_q, state_d;
  logic [1:0] speed_q, speed_d;
  logic [3:0] lo_q, lo_d;
  logic       er_lo_q, er_lo_d;
  logic [7:0] txd_q, txd_d;
  logic       en_q, en_d;
  logic       er_q, er_d;
  logic [1:0] eff_spd;

  // While idle the live speed input governs; once a frame starts the latched rate is frozen.
  assign eff_spd = (state_q == IDLE) ? speed : speed_q;

  // Next-state and output-byte selection; outputs hold unless a byte is emitted or the line is cleared.
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    lo_d    = lo_q;
    er_lo_d = er_lo_q;
    txd_d   = txd_q;
    en_d    = en_q;
    er_d    = er_q;

    if (state_q == IDLE) begin
      speed_d = speed;
    end

    if (eff_spd == SPD_1000) begin
      txd_d = mac_txd;
      en_d  = mac_tx_en;
      er_d  = mac_tx_er;
    end else if (nib_en) begin
      case (state_q)
        IDLE: begin
          if (mac_tx_en) begin
            lo_d    = mac_txd[3:0];
            er_lo_d = mac_tx_er;
            state_d = NIB_HI;
          end else begin
            // First idle slot after a frame has ended: the last byte has now been
            // held for a full byte time, so drop the line.
            txd_d = 8'h00;
            en_d  = 1'b0;
            er_d  = 1'b0;
          end
        end
        NIB_HI: begin
          if (mac_tx_en) begin
            txd_d   = {mac_txd[3:0], lo_q};
            en_d    = 1'b1;
            er_d    = er_lo_q | mac_tx_er;
            state_d = NIB_LO;
          end else begin
            // Odd nibble count: pad the stranded low nibble and flag it as errored.
            txd_d   = {PAD_NIBBLE, lo_q};
            en_d    = 1'b1;
            er_d    = 1'b1;
            state_d = IDLE;
          end
        end
        NIB_LO: begin
          if (mac_tx_en) begin
            lo_d    = mac_txd[3:0];
            er_lo_d = mac_tx_er;
            state_d = NIB_HI;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, latched rate, pending low nibble and registered GMII outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      speed_q <= 2'b00;
      lo_q    <= 4'h0;
      er_lo_q <= 1'b0;
      txd_q   <= 8'h00;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      lo_q    <= lo_d;
      er_lo_q <= er_lo_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      er_q    <= er_d;
    end
  end

  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign gmii_tx_er = er_q;

`ifdef MSGMII_CNVTX_STATS_EN
  logic [7:0] odd_cnt_q, odd_cnt_d;
  logic       pad_slot;

  // Count frames that ended on a lone low nibble, saturating at all-ones.
  always_comb begin
    pad_slot  = (state_q == NIB_HI) && nib_en && !mac_tx_en;
    odd_cnt_d = odd_cnt_q;
    if (pad_slot && (odd_cnt_q != 8'hFF)) begin
      odd_cnt_d = odd_cnt_q + 8'd1;
    end
  end

  // Odd-frame counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      odd_cnt_q <= 8'h00;
    end else begin
      odd_cnt_q <= odd_cnt_d;
    end
  end

  assign odd_cnt = odd_cnt_q;
`else
  assign odd_cnt = 8'h00;
`endif

endmodule

// File: doc/msgmii_cnvtx.md
MSGMII_CNVTX -- requirements
Module: msgmii_cnvtx

Interface
REQ-001 SHALL have parameter PAD_NIBBLE, default 4'h0: the high nibble used to pad an odd-length 10/100 frame.
REQ-002 SHALL have port clk, input, 1: the single clock (125 MHz GMII-side clock); all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port speed, input, 2: line rate; 2'b10 = 1000, 2'b01 = 100, 2'b00 = 10, 2'b11 treated as 10.
REQ-005 SHALL have port nib_en, input, 1: nibble qualifier at 10/100 (one pulse per MII nibble slot); ignored at 1000.
REQ-006 SHALL have port mac_txd, input, 8: a full byte at 1000; only bits[3:0] are used at 10/100.
REQ-007 SHALL have port mac_tx_en, input, 1: MAC transmit enable.
REQ-008 SHALL have port mac_tx_er, input, 1: MAC transmit error.
REQ-009 SHALL have port gmii_txd, output, 8: byte toward the SGMII PCS transmit path.
REQ-010 SHALL have port gmii_tx_en, output, 1: PCS transmit enable.
REQ-011 SHALL have port gmii_tx_er, output, 1: PCS transmit error.
REQ-012 SHALL have port odd_cnt, output, 8: saturating count of odd-nibble frames.

Function
REQ-013 SHALL latch speed into speed_q every cycle while in state IDLE, and SHALL hold speed_q constant from frame start until return to IDLE.
REQ-014 At 1000: gmii_txd/en/er SHALL equal mac_txd/tx_en/tx_er with exactly 1-cycle register latency; the FSM SHALL stay in IDLE.
REQ-015 At 10/100, the FSM SHALL have states IDLE, NIB_LO, NIB_HI; only cycles with nib_en=1 ("slots") advance it.
REQ-016 IDLE: on a slot with mac_tx_en=1, SHALL capture the low nibble and its tx_er, then go to NIB_HI; this aligns the first nibble to bits[3:0].
REQ-017 NIB_HI: on a slot with mac_tx_en=1, SHALL register gmii_txd={nibble, lo}, gmii_tx_en=1, gmii_tx_er=(er_lo|er_hi) on the next edge, then go to NIB_LO.
REQ-018 NIB_LO: on a slot with mac_tx_en=1, SHALL capture lo/er_lo and go to NIB_HI.
REQ-018a NIB_LO: on a slot with mac_tx_en=0, SHALL go to IDLE.
REQ-019 NIB_HI: on a slot with mac_tx_en=0 (odd length), SHALL emit {PAD_NIBBLE, lo} with en=1 and er=1, increment odd_cnt, and go to IDLE.
REQ-020 At 10/100, gmii outputs SHALL change only on byte emission, or on the slot after which the FSM returns to IDLE with no emission (en=0, er=0, txd=0). Bytes are otherwise held, which gives the 10x/100x SGMII replication.
REQ-021 Worked example: preamble nibbles 5,5,...,5,D SHALL produce bytes 0x55,...,0xD5.
REQ-022 nib_en asserted on consecutive cycles SHALL be legal, with every cycle treated as a slot.
REQ-023 odd_cnt SHALL saturate at 8'hFF, with no wrap-around.

Reset
REQ-024 On rst=1 at a clock edge, the outputs SHALL be gmii_txd=8'h00, gmii_tx_en=0, gmii_tx_er=0, odd_cnt=8'h00, and the FSM and speed_q SHALL also reset (FSM=IDLE, speed_q=2'b00).
REQ-025 Reset mid-frame SHALL drop the frame with no pad byte and no odd_cnt increment.

Configuration
REQ-026 Macro MSGMII_CNVTX_STATS_EN defined: odd_cnt SHALL be implemented per REQ-019/REQ-023.
REQ-027 Macro MSGMII_CNVTX_STATS_EN undefined: odd_cnt SHALL be constant 8'h00 with no counter flops; pad behaviour SHALL be unchanged.

Structure
REQ-028 The shared package msgmii_pkg SHALL hold the speed encodings (SPD_1000=2'b10, SPD_100=2'b01, SPD_10=2'b00) and the FSM state enumeration.
REQ-029 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-030 Scenario: speed=10, stream 0x55,0xD5,0xA1 with tx_en=1, then tx_en=0 -> the same bytes appear one cycle later, then en=0.
REQ-031 Scenario: speed=01, nib_en every 5 cycles, nibbles 5,5,5,D,1,A then tx_en=0 -> bytes 0x55,0xD5,0xA1, each held 10 cycles, then en=0, odd_cnt=0.
REQ-032 Scenario: speed=00, nibbles 3,C,7 then tx_en=0 -> 0xC3 (er=0), then 0x07 (er=1), odd_cnt=1.
REQ-033 Scenario: tx_er=1 on a high nibble only -> that byte has er=1 and neighbouring bytes have er=0.
REQ-034 Scenario: speed changes 01->10 mid-frame -> the frame completes at 100 behaviour, and 1000 takes effect after IDLE.
REQ-035 Scenario: rst asserted in NIB_HI -> next cycle all outputs are 0, and a following frame aligns correctly.
